memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: MEMORY_RESPONDER

---
 rtl/memory_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - wait-state memory responder; MEM_RESPONDER_RANGE_CHECK_EN enables out-of-range errors
module memory_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [25:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    input  logic        READ,
    input  logic        WRITE,
    output logic        READY,
    output logic        ERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam int AW = 26;
`else
    localparam int AW = DEPTH_LOG2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [AW-1:0]           r_addr;
    logic [31:0]             r_data;
    logic                    r_wr;
    logic [31:0]             r_dout;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_start;
    logic                    w_access;
    logic                    w_oor;
    logic [DEPTH_LOG2-1:0]   w_idx;

    assign w_start  = (r_state == S_IDLE) && (READ ^ WRITE);
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[DEPTH_LOG2-1:0];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic r_err;

    assign w_oor = |(r_addr >> DEPTH_LOG2);
    assign ERR   = (r_state == S_RESP) && r_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_access) begin
            r_err <= w_oor;
        end
    end
`else
    assign w_oor = 1'b0;
    assign ERR   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (READ ^ WRITE) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= 32'h0;
            r_wr    <= 1'b0;
            r_dout  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr <= ADDR[AW-1:0];
                r_data <= DATA_IN;
                r_wr   <= WRITE;
                r_cnt  <= 4'(WAIT_STATES);
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_wr) begin
                r_dout <= w_oor ? 32'hFFFF_FFFF : r_mem[w_idx];
            end
        end
    end

    // Reset forces IDLE asynchronously, so an aborted access never reaches this write.
    always_ff @(posedge CLK) begin
        if (w_access && r_wr && !w_oor) begin
            r_mem[w_idx] <= r_data;
        end
    end

    assign DATA_OUT = r_dout;
    assign READY    = (r_state == S_RESP);

endmodule
